// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - five-stage pipeline hazard/sequencing controller
// Handles load-use stalls, EX-resolved redirects and multi-cycle mul/div waits.
module pipeline_hazard_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             id_muldiv,
   input  logic             md_done,
   output logic             md_start,
   output logic             pc_write,
   output logic             if_id_stall,
   output logic             if_flush,
   output logic             id_ex_flush,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int TO_W = $clog2(MD_TIMEOUT + 1);

   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t          state, state_next;
   logic [TO_W-1:0] to_cnt;
   logic            luh;
   logic            md_timeout;

   assign luh = ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   assign md_timeout = (to_cnt == TO_W'(MD_TIMEOUT - 1)) && !md_done;

   always_comb begin
      state_next  = state;
      pc_write    = 1'b1;
      if_id_stall = 1'b0;
      if_flush    = 1'b0;
      id_ex_flush = 1'b0;
      md_start    = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         if_flush    = 1'b1;
         id_ex_flush = 1'b1;
         state_next  = RUN;
      end else begin
         case (state)
            RUN: begin
               // A taken redirect squashes whatever hazard ID was reporting.
               if (ex_branch_taken) begin
                  if_flush    = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (luh) begin
                  pc_write    = 1'b0;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (id_muldiv) begin
                  md_start    = 1'b1;
                  pc_write    = 1'b0;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
                  state_next  = MD_WAIT;
               end
            end
            MD_WAIT: begin
               if (md_done || md_timeout) begin
                  state_next = RUN;
               end else begin
                  pc_write    = 1'b0;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         to_cnt       <= '0;
         md_error     <= 1'b0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= state_next;
         // RUN keeps the timeout counter cleared so MD_WAIT always starts at 0.
         if (state == RUN)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TO_W'(1);
         if ((state == MD_WAIT) && md_timeout)
            md_error <= 1'b1;
         if (!pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (if_flush && (flush_events != '1))
            flush_events <= flush_events + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Directed scenarios plus randomized traffic against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

   localparam int TO    = 8;
   localparam int CW    = 16;
   localparam int SAT   = 65535;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs2, ex_mem_read, ex_branch_taken, id_muldiv, md_done;
   logic          md_start, pc_write, if_id_stall, if_flush, id_ex_flush, md_error;
   logic [CW-1:0] stall_cycles, flush_events;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_md;
   int m_wait;
   bit m_err;
   int m_stall;
   int m_flush;
   // expected combinational outputs for the current inputs
   bit e_pc, e_st, e_iff, e_idf, e_start;

   pipeline_hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .id_muldiv(id_muldiv), .md_done(md_done),
      .md_start(md_start), .pc_write(pc_write), .if_id_stall(if_id_stall),
      .if_flush(if_flush), .id_ex_flush(id_ex_flush), .md_error(md_error),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   function automatic bit load_use();
      if (!ex_mem_read || ex_rd == 0) return 0;
      return (ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2);
   endfunction

   function automatic bit md_releases();
      return md_done || (m_wait == TO - 1);
   endfunction

   task automatic model_eval();
      {e_pc, e_st, e_iff, e_idf, e_start} = 5'b10000;
      if (reset)                 {e_pc, e_st, e_iff, e_idf, e_start} = 5'b00110;
      else if (m_md)             {e_pc, e_st, e_iff, e_idf, e_start} = md_releases() ? 5'b10000 : 5'b01010;
      else if (ex_branch_taken)  {e_pc, e_st, e_iff, e_idf, e_start} = 5'b10110;
      else if (load_use())       {e_pc, e_st, e_iff, e_idf, e_start} = 5'b01010;
      else if (id_muldiv)        {e_pc, e_st, e_iff, e_idf, e_start} = 5'b01011;
   endtask

   task automatic model_commit();
      if (reset) begin
         m_md = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!e_pc)  m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
         if (e_iff)  m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
         if (m_md) begin
            if (md_releases()) begin
               if (!md_done) m_err = 1;
               m_md = 0;
            end else begin
               m_wait++;
            end
         end else if (e_start) begin
            m_md = 1;
            m_wait = 0;
         end
      end
   endtask

   task automatic quiet_inputs();
      reset = 0; id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 0; ex_rd = 5'd0;
      ex_mem_read = 0; ex_branch_taken = 0; id_muldiv = 0; md_done = 0;
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic test_reset();
      quiet_inputs();
      reset = 1;
      model_eval();
      @(negedge clk);
      checks++;
      if ({pc_write, if_id_stall, if_flush, id_ex_flush, md_start} !== 5'b00110) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00110",
                  {pc_write, if_id_stall, if_flush, id_ex_flush, md_start});
      end
      advance();
      advance();
      checks++;
      if (stall_cycles !== 0 || flush_events !== 0 || md_error !== 0) begin
         errors++;
         $display("FAIL reset_state got stall=%0d flush=%0d err=%b want 0 0 0",
                  stall_cycles, flush_events, md_error);
      end
      reset = 0;
   endtask

   task automatic test_load_use();
      int s0;
      quiet_inputs();
      s0 = m_stall;
      ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5;
      model_eval();
      @(negedge clk);
      checks++;
      if ({pc_write, if_id_stall, id_ex_flush, if_flush} !== 4'b0110) begin
         errors++;
         $display("FAIL luh_stall got %b want 0110",
                  {pc_write, if_id_stall, id_ex_flush, if_flush});
      end
      advance();
      ex_mem_read = 0;
      model_eval();
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b1 || if_id_stall !== 1'b0 || stall_cycles !== CW'(s0 + 1)) begin
         errors++;
         $display("FAIL luh_one_cycle got pc=%b st=%b cnt=%0d want 1 0 %0d",
                  pc_write, if_id_stall, stall_cycles, s0 + 1);
      end
      advance();
      ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
      model_eval();
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b1 || if_id_stall !== 1'b0 || id_ex_flush !== 1'b0) begin
         errors++;
         $display("FAIL luh_x0 got pc=%b st=%b idf=%b want 1 0 0",
                  pc_write, if_id_stall, id_ex_flush);
      end
      advance();
      ex_mem_read = 1; ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_uses_rs2 = 1;
      model_eval();
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b0 || if_id_stall !== 1'b1) begin
         errors++;
         $display("FAIL luh_rs2 got pc=%b st=%b want 0 1", pc_write, if_id_stall);
      end
      advance();
      id_uses_rs2 = 0;
      model_eval();
      @(negedge clk);
      checks++;
      if (pc_write !== 1'b1) begin
         errors++;
         $display("FAIL luh_rs2_unused got pc=%b want 1", pc_write);
      end
      advance();
      quiet_inputs();
   endtask

   task automatic test_branch();
      int f0;
      quiet_inputs();
      f0 = m_flush;
      ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_muldiv = 1;
      model_eval();
      @(negedge clk);
      checks++;
      if ({if_flush, id_ex_flush, pc_write, if_id_stall, md_start} !== 5'b11100) begin
         errors++;
         $display("FAIL branch_prio got %b want 11100",
                  {if_flush, id_ex_flush, pc_write, if_id_stall, md_start});
      end
      advance();
      quiet_inputs();
      model_eval();
      @(negedge clk);
      checks++;
      if (flush_events !== CW'(f0 + 1) || md_start !== 1'b0) begin
         errors++;
         $display("FAIL branch_count got flush=%0d start=%b want %0d 0",
                  flush_events, md_start, f0 + 1);
      end
      advance();
   endtask

   task automatic test_muldiv();
      int s0, starts, stalls;
      bit released;
      quiet_inputs();
      s0 = m_stall; starts = 0; stalls = 0; released = 0;
      id_muldiv = 1;
      for (int c = 0; c <= 5; c++) begin
         md_done = (c == 5);
         model_eval();
         @(negedge clk);
         starts += md_start;
         stalls += !pc_write;
         if (c == 5) released = pc_write && !if_id_stall && !id_ex_flush;
         advance();
      end
      quiet_inputs();
      checks++;
      if (starts != 1 || stalls != 5 || !released) begin
         errors++;
         $display("FAIL muldiv_seq got starts=%0d stalls=%0d rel=%b want 1 5 1",
                  starts, stalls, released);
      end
      checks++;
      if (stall_cycles !== CW'(s0 + 5)) begin
         errors++;
         $display("FAIL muldiv_count got %0d want %0d", stall_cycles, s0 + 5);
      end
   endtask

   task automatic test_timeout();
      int waits;
      bit seen;
      quiet_inputs();
      id_muldiv = 1;
      model_eval();
      advance();
      waits = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         model_eval();
         @(negedge clk);
         waits++;
         if (pc_write) seen = 1;
         advance();
      end
      checks++;
      if (!seen || waits != TO) begin
         errors++;
         $display("FAIL timeout_release got seen=%b wait_cycles=%0d want 1 %0d", seen, waits, TO);
      end
      checks++;
      if (md_error !== 1'b1) begin
         errors++;
         $display("FAIL timeout_error got %b want 1", md_error);
      end
      id_muldiv = 0;
      for (int c = 0; c < 4; c++) begin
         model_eval();
         advance();
      end
      checks++;
      if (md_error !== 1'b1 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky got err=%b pc=%b want 1 1", md_error, pc_write);
      end
   endtask

   task automatic test_reset_in_wait();
      quiet_inputs();
      id_muldiv = 1;
      model_eval();
      advance();
      for (int c = 0; c < 2; c++) begin
         model_eval();
         advance();
      end
      reset = 1;
      model_eval();
      advance();
      reset = 0; id_muldiv = 0;
      model_eval();
      @(negedge clk);
      checks++;
      if (md_error !== 0 || stall_cycles !== 0 || flush_events !== 0 || pc_write !== 1) begin
         errors++;
         $display("FAIL reset_abort got err=%b stall=%0d flush=%0d pc=%b want 0 0 0 1",
                  md_error, stall_cycles, flush_events, pc_write);
      end
      advance();
      md_done = 1;
      model_eval();
      @(negedge clk);
      checks++;
      if (pc_write !== 1 || md_start !== 0 || if_id_stall !== 0) begin
         errors++;
         $display("FAIL done_in_run got pc=%b start=%b st=%b want 1 0 0",
                  pc_write, md_start, if_id_stall);
      end
      advance();
      quiet_inputs();
      model_eval();
      @(negedge clk);
      checks++;
      if (md_error !== 0 || pc_write !== 1) begin
         errors++;
         $display("FAIL done_ignored got err=%b pc=%b want 0 1", md_error, pc_write);
      end
      advance();
   endtask

   task automatic test_random();
      int bad = 0;
      bit prev_start = 0;
      for (int c = 0; c < 3000; c++) begin
         reset           = ($urandom_range(0, 99) == 0);
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         ex_rd           = 5'($urandom_range(0, 3));
         ex_mem_read     = ($urandom_range(0, 2) == 0);
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         id_muldiv       = ($urandom_range(0, 3) == 0);
         md_done         = ($urandom_range(0, 5) == 0);
         model_eval();
         @(negedge clk);
         checks++;
         if ({pc_write, if_id_stall, if_flush, id_ex_flush, md_start} !==
             {e_pc, e_st, e_iff, e_idf, e_start} ||
             md_error !== m_err || stall_cycles !== CW'(m_stall) ||
             flush_events !== CW'(m_flush) || (prev_start && md_start)) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_cyc%0d got out=%b err=%b st=%0d fl=%0d want out=%b err=%b st=%0d fl=%0d",
                        c, {pc_write, if_id_stall, if_flush, id_ex_flush, md_start}, md_error,
                        stall_cycles, flush_events, {e_pc, e_st, e_iff, e_idf, e_start},
                        m_err, m_stall, m_flush);
         end
         prev_start = md_start;
         advance();
      end
      quiet_inputs();
   endtask

   task automatic test_saturation();
      quiet_inputs();
      reset = 1;
      model_eval();
      advance();
      reset = 0;
      ex_mem_read = 1; ex_rd = 5'd4; id_rs1 = 5'd4;
      for (int c = 0; c < 65536 + 3; c++) begin
         model_eval();
         advance();
      end
      checks++;
      if (stall_cycles !== 16'hFFFF || stall_cycles !== CW'(m_stall)) begin
         errors++;
         $display("FAIL stall_saturate got %h want ffff", stall_cycles);
      end
      quiet_inputs();
   endtask

   initial begin
      quiet_inputs();
      m_md = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
      test_reset();
      test_load_use();
      test_branch();
      test_muldiv();
      test_timeout();
      test_reset_in_wait();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
